minisys_input_conditioner: RTL and testbench
============================================

# minisys_input_conditioner

Parametrised front end for the Minisys board's slide switches and push buttons. It sits between the raw board pins and the CPU/IO top level. Each channel is synchronised into `Minisys_Clock`, then debounced. The block produces stable levels plus single-cycle change, press and release pulses. Buttons can optionally generate hold/auto-repeat pulses.

## Interface
- `SW_WIDTH`, 24, number of switch channels (≥1)
- `BTN_WIDTH`, 5, number of button channels (≥1)
- `SYNC_STAGES`, 2, synchroniser flops per channel (≥2)
- `DEBOUNCE_CYCLES`, 20000, consecutive disagreeing cycles required to accept a new level (≥1)
- `HOLD_CYCLES`, 1000000, cycles a button must stay pressed before the first hold pulse (≥1; used only with the hold feature)
- `REPEAT_CYCLES`, 200000, cycles between repeat hold pulses (≥1; used only with the hold feature)

Ports:
- `Minisys_Clock`  in  1  sole clock; all state is on its rising edge
- `Minisys_Reset_n`  in  1  asynchronous, active-low reset
- `sw_raw`  in  SW_WIDTH  unsynchronised switch pins
- `btn_raw`  in  BTN_WIDTH  unsynchronised button pins (1 = pressed)
- `sw_stable`  out  SW_WIDTH  debounced switch levels
- `sw_changed`  out  SW_WIDTH  one-cycle pulse per channel when `sw_stable` toggles
- `btn_level`  out  BTN_WIDTH  debounced button levels
- `btn_press`  out  BTN_WIDTH  one-cycle pulse on a debounced 0→1 transition
- `btn_release`  out  BTN_WIDTH  one-cycle pulse on a debounced 1→0 transition
- `btn_hold`  out  BTN_WIDTH  one-cycle hold/repeat pulses
- `any_event`  out  1  OR of all `sw_changed`, `btn_press` and `btn_release` bits

## Operation
- Switches and buttons use the same per-channel pipeline:
  - a synchroniser chain of `SYNC_STAGES` flops, producing `s`;
  - a debounced state `q`, driven to the output;
  - a counter `c` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Debounce rule, evaluated each cycle:
  - `s == q`: `c` ← 0.
  - `s != q` and `c == DEBOUNCE_CYCLES-1`: `q` ← `s`, `c` ← 0, and the edge pulse is asserted next cycle together with the new `q`.
  - Otherwise: `c` ← `c+1`.
- Any glitch where `s` returns to `q` before the count completes clears `c`. No partial credit is carried across glitches.
- `DEBOUNCE_CYCLES=1`: `q` follows `s` one cycle later, with no filtering.
- Edge pulses:
  - `sw_changed` = `q` toggled in the previous update.
  - `btn_press` = 0→1, `btn_release` = 1→0.
  - Each pulse is exactly one cycle and is registered.
- Hold logic (only when `INPUT_COND_HOLD_EN` is defined), per button:
  - Counter `h`, width `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)`, plus a flag `rep`.
  - While `btn_level == 0`: `h` ← 0 and `rep` ← 0.
  - While `btn_level == 1`: `h` increments.
  - When `h` reaches `HOLD_CYCLES` with `rep == 0`, or `REPEAT_CYCLES` with `rep == 1`: pulse `btn_hold`, `h` ← 1, `rep` ← 1.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.
- Reset: every synchroniser flop, `q`, `c`, `h`, `rep` and all outputs go to 0 immediately on `Minisys_Reset_n` low.
  - Reset mid-debounce discards the partial count.
  - A switch held at 1 through reset is re-acquired as a fresh 0→1 change after reset release.

## Timing
- Raw 0→1 stable before rising edge 1 (first edge after reset release) → `sw_stable`/`btn_level` high after edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- The matching pulse is high during that same cycle only.
- The first `btn_hold` comes `HOLD_CYCLES` cycles after the `btn_press` cycle. Each following pulse comes every `REPEAT_CYCLES` cycles while the button stays held.
- A release during a hold or repeat interval suppresses any further `btn_hold`. No pulse coincides with `btn_release`.
- `any_event` is combinational OR of the registered pulses, so it adds zero extra latency.
- Counters never wrap: `c` resets at `DEBOUNCE_CYCLES-1`, and `h` resets to 1 on each hold pulse.

## Configuration
- `INPUT_COND_HOLD_EN`:
  - Defined: hold/auto-repeat logic is generated as described above.
  - Undefined: no `h`/`rep` registers exist, `btn_hold` is tied to 0, and `HOLD_CYCLES`/`REPEAT_CYCLES` are ignored.
- All other behaviour is identical in both builds.

## Test plan
Bench parameters: `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=8`, `REPEAT_CYCLES=3`, `SW_WIDTH=24`, `BTN_WIDTH=5`.

- Reset: hold `Minisys_Reset_n`=0 with `sw_raw`=24'hFFFFFF → all outputs 0. Release → `sw_stable`=24'hFFFFFF and `sw_changed`=24'hFFFFFF for one cycle at edge 6; `any_event`=1 in that cycle only.
- Glitch rejection: `sw_raw[15]` high for 3 cycles, then low → `sw_stable[15]` stays 0 and no pulse. Then high for 10 cycles → `sw_stable[15]`=1 at edge 6 after the rise, and `sw_changed[15]` is one cycle.
- Buttons: `btn_raw`=5'b00001 asserted for 20 cycles → one `btn_press[0]` at edge 6. After release → one `btn_release[0]` 6 cycles later. `btn_press`/`btn_release[4:1]` stay 0.
- Hold (macro defined): `btn_raw[2]` held for 25 cycles after `btn_press[2]` → `btn_hold[2]` pulses at +8, +11, +14, +17, +20, +23 cycles. Release → no further pulses. With the macro undefined → `btn_hold` is 0 throughout.
- Simultaneous events: `sw_raw[23]`, `sw_raw[0]` and `btn_raw[4]` rise on the same edge → all three pulses are high in the same cycle and `any_event` is a single one-cycle pulse.
- Reset mid-operation: assert reset 2 cycles into a debounce → outputs 0 immediately. After release, full `SYNC_STAGES+DEBOUNCE_CYCLES`=6-cycle latency is required again.

Source files
------------

// File: rtl/minisys_input_conditioner.sv
// rtl/minisys_input_conditioner.sv - switch/button synchroniser, debouncer and edge/hold pulse generator
// Optional hold/auto-repeat pulses on buttons: define INPUT_COND_HOLD_EN.
module minisys_input_conditioner #(
    parameter int SW_WIDTH        = 24,
    parameter int BTN_WIDTH       = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES   = 200000
) (
    input  logic                 Minisys_Clock,
    input  logic                 Minisys_Reset_n,
    input  logic [SW_WIDTH-1:0]  sw_raw,
    input  logic [BTN_WIDTH-1:0] btn_raw,
    output logic [SW_WIDTH-1:0]  sw_stable,
    output logic [SW_WIDTH-1:0]  sw_changed,
    output logic [BTN_WIDTH-1:0] btn_level,
    output logic [BTN_WIDTH-1:0] btn_press,
    output logic [BTN_WIDTH-1:0] btn_release,
    output logic [BTN_WIDTH-1:0] btn_hold,
    output logic                 any_event
);
    localparam int N  = SW_WIDTH + BTN_WIDTH;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] raw, q, rise, fall;

`ifdef INPUT_COND_HOLD_EN
    logic [BTN_WIDTH-1:0] btn_next;
`endif

    // Switches occupy the low channels, buttons the high ones.
    assign raw = {btn_raw, sw_raw};

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic [CW-1:0]          c;
        logic                   s, acc, q_r, rise_r, fall_r;

        assign s       = sync_r[SYNC_STAGES-1];
        assign acc     = (s != q_r) && (c == C_LAST);
        assign q[i]    = q_r;
        assign rise[i] = rise_r;
        assign fall[i] = fall_r;

`ifdef INPUT_COND_HOLD_EN
        if (i >= SW_WIDTH) begin : g_btn_next
            assign btn_next[i-SW_WIDTH] = q_r ^ acc;
        end
`endif

        always_ff @(posedge Minisys_Clock or negedge Minisys_Reset_n) begin
            if (!Minisys_Reset_n) begin
                sync_r <= '0;
                c      <= '0;
                q_r    <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], raw[i]};
                q_r    <= q_r ^ acc;
                rise_r <= acc & ~q_r;
                fall_r <= acc & q_r;
                // Any agreeing sample discards the partial count.
                if ((s == q_r) || acc) begin
                    c <= '0;
                end else begin
                    c <= c + CW'(1);
                end
            end
        end
    end

    assign sw_stable   = q[SW_WIDTH-1:0];
    assign sw_changed  = rise[SW_WIDTH-1:0] | fall[SW_WIDTH-1:0];
    assign btn_level   = q[N-1:SW_WIDTH];
    assign btn_press   = rise[N-1:SW_WIDTH];
    assign btn_release = fall[N-1:SW_WIDTH];
    assign any_event   = |{sw_changed, btn_press, btn_release};

`ifdef INPUT_COND_HOLD_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] H_FIRST = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] H_REP   = HW'(REPEAT_CYCLES);

    // Counting follows the level being loaded this edge so the first pulse
    // lands exactly HOLD_CYCLES after the press cycle.
    for (genvar b = 0; b < BTN_WIDTH; b++) begin : g_hold
        logic [HW-1:0] h;
        logic          rep, hold_r;

        assign btn_hold[b] = hold_r;

        always_ff @(posedge Minisys_Clock or negedge Minisys_Reset_n) begin
            if (!Minisys_Reset_n) begin
                h      <= '0;
                rep    <= 1'b0;
                hold_r <= 1'b0;
            end else if (!btn_next[b]) begin
                h      <= '0;
                rep    <= 1'b0;
                hold_r <= 1'b0;
            end else if (h == (rep ? H_REP : H_FIRST)) begin
                h      <= HW'(1);
                rep    <= 1'b1;
                hold_r <= 1'b1;
            end else begin
                h      <= h + HW'(1);
                hold_r <= 1'b0;
            end
        end
    end
`else
    assign btn_hold = '0;
`endif

endmodule

// File: tb/tb_minisys_input_conditioner.sv
// tb/tb_minisys_input_conditioner.sv - self-checking bench for minisys_input_conditioner
module tb_minisys_input_conditioner;
    localparam int SW   = 24;
    localparam int BT   = 5;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int REP  = 3;
    localparam int N    = SW + BT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] sw_raw, sw_stable, sw_changed;
    logic [BT-1:0] btn_raw, btn_level, btn_press, btn_release, btn_hold;
    logic          any_event;

    int nvec = 0;
    int nerr = 0;

    minisys_input_conditioner #(
        .SW_WIDTH(SW), .BTN_WIDTH(BT), .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .Minisys_Clock(clk), .Minisys_Reset_n(rst_n),
        .sw_raw(sw_raw), .btn_raw(btn_raw),
        .sw_stable(sw_stable), .sw_changed(sw_changed),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_hold(btn_hold), .any_event(any_event)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DEB synchronised
    // samples (raw seen SYNC edges earlier) all disagree with it.
    logic [N-1:0]  win [SYNC+DEB];
    logic [N-1:0]  m_q, m_rise, m_fall;
    logic [BT-1:0] m_hold;
    int            age [BT];

    task automatic model_reset();
        for (int k = 0; k < SYNC + DEB; k++) win[k] = '0;
        m_q = '0; m_rise = '0; m_fall = '0; m_hold = '0;
        for (int b = 0; b < BT; b++) age[b] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] raw);
        logic [N-1:0] acc;
        for (int k = SYNC + DEB - 1; k > 0; k--) win[k] = win[k-1];
        win[0] = raw;
        acc = '1;
        for (int j = 0; j < DEB; j++) acc &= win[SYNC+j] ^ m_q;
        m_rise = acc & ~m_q;
        m_fall = acc & m_q;
        m_q    = m_q ^ acc;
        for (int b = 0; b < BT; b++) begin
            m_hold[b] = 1'b0;
            if (m_q[SW+b]) begin
                age[b] = m_rise[SW+b] ? 0 : age[b] + 1;
`ifdef INPUT_COND_HOLD_EN
                if (age[b] >= HOLD && (age[b] - HOLD) % REP == 0) m_hold[b] = 1'b1;
`endif
            end else begin
                age[b] = 0;
            end
        end
    endtask

    function automatic logic [68:0] expv();
        return {m_q[SW-1:0], m_rise[SW-1:0] | m_fall[SW-1:0], m_q[N-1:SW],
                m_rise[N-1:SW], m_fall[N-1:SW], m_hold, |(m_rise | m_fall)};
    endfunction

    function automatic logic [68:0] obsv();
        return {sw_stable, sw_changed, btn_level, btn_press, btn_release, btn_hold, any_event};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge({btn_raw, sw_raw});
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; sw_raw = '1; btn_raw = '0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        nvec++;
        if (obsv() !== '0) begin nerr++; $display("FAIL reset_outputs got %h want 0", obsv()); end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL reset_model edge %0d got %h want %h", i, obsv(), expv()); end
            if (i == 5) begin
                nvec++;
                if (sw_stable !== '0) begin nerr++; $display("FAIL reset_early got %h want 0", sw_stable); end
            end
            if (i == 6) begin
                nvec++;
                if (sw_stable !== 24'hFFFFFF || sw_changed !== 24'hFFFFFF || any_event !== 1'b1) begin
                    nerr++; $display("FAIL reset_acquire stable %h changed %h any %b want FFFFFF FFFFFF 1", sw_stable, sw_changed, any_event);
                end
            end
            if (i == 7) begin
                nvec++;
                if (sw_changed !== '0 || any_event !== 1'b0) begin
                    nerr++; $display("FAIL reset_pulse_width changed %h any %b want 0 0", sw_changed, any_event);
                end
            end
        end
    endtask

    task automatic test_glitch();
        sw_raw = '0;
        for (int i = 0; i < 10; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL glitch_settle got %h want %h", obsv(), expv()); end
        end
        sw_raw[15] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) sw_raw[15] = 1'b0;
            tick(); nvec++;
            if (obsv() !== expv() || sw_stable[15] !== 1'b0 || sw_changed[15] !== 1'b0) begin
                nerr++; $display("FAIL glitch_reject got %h want %h", obsv(), expv());
            end
        end
        sw_raw[15] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL glitch_accept edge %0d got %h want %h", i, obsv(), expv()); end
            if (i == 5 || i == 6 || i == 7) begin
                nvec++;
                if (sw_stable[15] !== (i >= 6) || sw_changed[15] !== (i == 6)) begin
                    nerr++; $display("FAIL glitch_edge%0d stable %b changed %b", i, sw_stable[15], sw_changed[15]);
                end
            end
        end
    endtask

    task automatic test_buttons();
        int npress = 0, nrel = 0, at_press = -1, at_rel = -1, nother = 0;
        btn_raw = 5'b00001;
        for (int i = 1; i <= 20; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL btn_model_press edge %0d got %h want %h", i, obsv(), expv()); end
            if (btn_press[0]) begin npress++; at_press = i; end
            if (btn_press[4:1] !== 4'b0 || btn_release[4:1] !== 4'b0) nother++;
        end
        btn_raw = 5'b00000;
        for (int i = 1; i <= 12; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL btn_model_release edge %0d got %h want %h", i, obsv(), expv()); end
            if (btn_release[0]) begin nrel++; at_rel = i; end
            if (btn_press[4:1] !== 4'b0 || btn_release[4:1] !== 4'b0) nother++;
        end
        nvec++;
        if (npress != 1 || at_press != 6) begin nerr++; $display("FAIL btn_press count %0d at %0d want 1 at 6", npress, at_press); end
        nvec++;
        if (nrel != 1 || at_rel != 6) begin nerr++; $display("FAIL btn_release count %0d at %0d want 1 at 6", nrel, at_rel); end
        nvec++;
        if (nother != 0) begin nerr++; $display("FAIL btn_other_channels got %0d cycles want 0", nother); end
    endtask

    task automatic test_hold();
        int got_q[$];
        int exp_q[$];
        bit found = 0;
        int late = 0;
`ifdef INPUT_COND_HOLD_EN
        exp_q = '{8, 11, 14, 17, 20, 23};
`endif
        btn_raw = 5'b00100;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL hold_model_press got %h want %h", obsv(), expv()); end
            if (btn_press[2]) found = 1;
        end
        nvec++;
        if (!found) begin nerr++; $display("FAIL hold_press_timeout got 0 want 1"); end
        for (int off = 1; off <= 25; off++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL hold_model off %0d got %h want %h", off, obsv(), expv()); end
            if (btn_hold[2]) got_q.push_back(off);
        end
        nvec++;
        if (got_q != exp_q) begin nerr++; $display("FAIL hold_offsets got %p want %p", got_q, exp_q); end
        btn_raw = 5'b00000;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL hold_model_release got %h want %h", obsv(), expv()); end
            if (btn_release[2]) begin
                found = 1; nvec++;
                if (btn_hold !== '0) begin nerr++; $display("FAIL hold_on_release got %b want 0", btn_hold); end
            end
        end
        nvec++;
        if (!found) begin nerr++; $display("FAIL hold_release_timeout got 0 want 1"); end
        for (int i = 0; i < 15; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL hold_model_after got %h want %h", obsv(), expv()); end
            if (btn_hold !== '0) late++;
        end
        nvec++;
        if (late != 0) begin nerr++; $display("FAIL hold_after_release got %0d pulses want 0", late); end
    endtask

    task automatic test_simultaneous();
        int nany = 0;
        sw_raw = '0; btn_raw = '0;
        for (int i = 0; i < 10; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL simul_settle got %h want %h", obsv(), expv()); end
        end
        sw_raw[23] = 1'b1; sw_raw[0] = 1'b1; btn_raw[4] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL simul_model edge %0d got %h want %h", i, obsv(), expv()); end
            if (any_event) nany++;
            if (i == 6) begin
                nvec++;
                if (sw_changed !== 24'h800001 || btn_press !== 5'b10000 || any_event !== 1'b1) begin
                    nerr++; $display("FAIL simul_pulses changed %h press %b any %b want 800001 10000 1", sw_changed, btn_press, any_event);
                end
            end
        end
        nvec++;
        if (nany != 1) begin nerr++; $display("FAIL simul_any_width got %0d want 1", nany); end
    endtask

    task automatic test_mid_reset();
        sw_raw = 24'h00A5C3; btn_raw = '0;
        repeat (4) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL midrst_model got %h want %h", obsv(), expv()); end
        end
        #2 rst_n = 1'b0;
        #1 model_reset();
        nvec++;
        if (obsv() !== '0) begin nerr++; $display("FAIL midrst_async got %h want 0", obsv()); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL midrst_reacq edge %0d got %h want %h", i, obsv(), expv()); end
            if (i == 5 || i == 6) begin
                nvec++;
                if (sw_stable !== (i == 6 ? 24'h00A5C3 : 24'h0) || sw_changed !== (i == 6 ? 24'h00A5C3 : 24'h0)) begin
                    nerr++; $display("FAIL midrst_latency edge %0d stable %h changed %h", i, sw_stable, sw_changed);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) sw_raw = sw_raw ^ 24'($urandom);
            for (int b = 0; b < BT; b++)
                if ($urandom_range(0, 29) == 0) btn_raw[b] = ~btn_raw[b];
            tick(); nvec++;
            if (obsv() !== expv()) begin nerr++; $display("FAIL random cycle %0d got %h want %h", i, obsv(), expv()); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_buttons();
        test_hold();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
